umi_unpack_reg: RTL and testbench

UMI_UNPACK_REG -- requirements
Module: umi_unpack_reg

---
 rtl/umi_unpack_reg.sv | 166 ++++++++++++++++
 tb/tb_umi_unpack_reg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_unpack_reg.sv
// UMI packet unpacker: decodes the command word at push time and buffers raw packet plus
// decoded fields in a 2-entry FIFO, so outputs are fully registered.
module umi_unpack_reg #(
   parameter int unsigned CW = 32,
   parameter int unsigned AW = 64,
   parameter int unsigned DW = 256
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          umi_in_valid,
   output logic          umi_in_ready,
   input  logic [CW-1:0] umi_in_cmd,
   input  logic [AW-1:0] umi_in_dstaddr,
   input  logic [AW-1:0] umi_in_srcaddr,
   input  logic [DW-1:0] umi_in_data,
   output logic          umi_out_valid,
   input  logic          umi_out_ready,
   output logic [4:0]    out_opcode,
   output logic [2:0]    out_size,
   output logic [7:0]    out_len,
   output logic [7:0]    out_atype,
   output logic [3:0]    out_qos,
   output logic [1:0]    out_prot,
   output logic          out_eom,
   output logic          out_eof,
   output logic          out_ex,
   output logic [1:0]    out_user,
   output logic [4:0]    out_hostid,
   output logic [18:0]   out_user_extended,
   output logic          out_atomic,
   output logic          out_error,
   output logic          out_link,
   output logic          out_link_resp,
   output logic [CW-1:0] out_cmd,
   output logic [AW-1:0] out_dstaddr,
   output logic [AW-1:0] out_srcaddr,
   output logic [DW-1:0] out_data,
   output logic [15:0]   err_count
);

   typedef struct packed {
      logic [4:0]  opcode;
      logic [2:0]  size;
      logic [7:0]  len;
      logic [7:0]  atype;
      logic [3:0]  qos;
      logic [1:0]  prot;
      logic        eom;
      logic        eof;
      logic        ex;
      logic [1:0]  user;
      logic [4:0]  hostid;
      logic [18:0] user_ext;
      logic        atomic;
      logic        error;
      logic        link;
      logic        link_resp;
   } dec_t;

   dec_t          dec_in;
   dec_t          dec_q  [2];
   logic [CW-1:0] cmd_q  [2];
   logic [AW-1:0] dst_q  [2];
   logic [AW-1:0] src_q  [2];
   logic [DW-1:0] data_q [2];

   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    cnt_q, cnt_d;
   logic [15:0]   err_cnt_q;
   logic          push, pop, ext;

   assign umi_in_ready  = (cnt_q != 2'd2);
   assign umi_out_valid = (cnt_q != 2'd0);
   assign push          = umi_in_valid && umi_in_ready;
   assign pop           = umi_out_valid && umi_out_ready;

   always_comb begin
      dec_in           = '0;
      dec_in.opcode    = umi_in_cmd[4:0];
      dec_in.hostid    = umi_in_cmd[31:27];
      dec_in.atomic    = (umi_in_cmd[4:0] == 5'h09);
      dec_in.error     = (umi_in_cmd[4:0] == 5'h0F) && (umi_in_cmd[7:5] == 3'h0);
      dec_in.link      = (umi_in_cmd[4:0] == 5'h0F) && (umi_in_cmd[7:5] == 3'h1);
      dec_in.link_resp = (umi_in_cmd[4:0] == 5'h0E);
      ext              = dec_in.link || dec_in.link_resp || dec_in.error;
      // Extended-class commands reuse bits [26:8] as one opaque user field.
      if (ext) begin
         dec_in.user_ext = umi_in_cmd[26:8];
      end else begin
         dec_in.size = umi_in_cmd[7:5];
         dec_in.qos  = umi_in_cmd[19:16];
         dec_in.prot = umi_in_cmd[21:20];
         dec_in.eom  = umi_in_cmd[22];
         dec_in.eof  = umi_in_cmd[23];
         dec_in.ex   = umi_in_cmd[24];
         dec_in.user = umi_in_cmd[26:25];
         if (dec_in.atomic) begin
            dec_in.atype = umi_in_cmd[15:8];
         end else begin
            dec_in.len = umi_in_cmd[15:8];
         end
      end
   end

   always_comb begin
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         err_cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (push && dec_in.error && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   // Payload storage carries no reset; contents are meaningless while the slot is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         dec_q[wr_ptr_q]  <= dec_in;
         cmd_q[wr_ptr_q]  <= umi_in_cmd;
         dst_q[wr_ptr_q]  <= umi_in_dstaddr;
         src_q[wr_ptr_q]  <= umi_in_srcaddr;
         data_q[wr_ptr_q] <= umi_in_data;
      end
   end

   assign out_opcode        = dec_q[rd_ptr_q].opcode;
   assign out_size          = dec_q[rd_ptr_q].size;
   assign out_len           = dec_q[rd_ptr_q].len;
   assign out_atype         = dec_q[rd_ptr_q].atype;
   assign out_qos           = dec_q[rd_ptr_q].qos;
   assign out_prot          = dec_q[rd_ptr_q].prot;
   assign out_eom           = dec_q[rd_ptr_q].eom;
   assign out_eof           = dec_q[rd_ptr_q].eof;
   assign out_ex            = dec_q[rd_ptr_q].ex;
   assign out_user          = dec_q[rd_ptr_q].user;
   assign out_hostid        = dec_q[rd_ptr_q].hostid;
   assign out_user_extended = dec_q[rd_ptr_q].user_ext;
   assign out_atomic        = dec_q[rd_ptr_q].atomic;
   assign out_error         = dec_q[rd_ptr_q].error;
   assign out_link          = dec_q[rd_ptr_q].link;
   assign out_link_resp     = dec_q[rd_ptr_q].link_resp;
   assign out_cmd           = cmd_q[rd_ptr_q];
   assign out_dstaddr       = dst_q[rd_ptr_q];
   assign out_srcaddr       = src_q[rd_ptr_q];
   assign out_data          = data_q[rd_ptr_q];
   assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_umi_unpack_reg.sv
// Scoreboard bench for umi_unpack_reg: directed command vectors with hand-decoded expectations,
// popped and compared by an independent output monitor.
module tb_umi_unpack_reg;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [2:0]  size;
      logic [7:0]  len;
      logic [7:0]  atype;
      logic [3:0]  qos;
      logic [1:0]  prot;
      logic        eom;
      logic        eof;
      logic        ex;
      logic [1:0]  user;
      logic [4:0]  hostid;
      logic [18:0] uext;
      logic        atomic;
      logic        error;
      logic        link;
      logic        link_resp;
   } dec_t;

   typedef struct packed {
      dec_t         dec;
      logic [31:0]  cmd;
      logic [63:0]  dst;
      logic [63:0]  src;
      logic [255:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          umi_in_valid, umi_in_ready;
   logic [31:0]   umi_in_cmd;
   logic [63:0]   umi_in_dstaddr, umi_in_srcaddr;
   logic [255:0]  umi_in_data;
   logic          umi_out_valid, umi_out_ready;
   logic [4:0]    out_opcode, out_hostid;
   logic [2:0]    out_size;
   logic [7:0]    out_len, out_atype;
   logic [3:0]    out_qos;
   logic [1:0]    out_prot, out_user;
   logic          out_eom, out_eof, out_ex;
   logic [18:0]   out_user_extended;
   logic          out_atomic, out_error, out_link, out_link_resp;
   logic [31:0]   out_cmd;
   logic [63:0]   out_dstaddr, out_srcaddr;
   logic [255:0]  out_data;
   logic [15:0]   err_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   dec_t mon_act;
   logic [15:0] exp_err = 16'd0;

   always #5 clk = ~clk;

   umi_unpack_reg #(.CW(32), .AW(64), .DW(256)) dut (
      .clk(clk), .reset(reset),
      .umi_in_valid(umi_in_valid), .umi_in_ready(umi_in_ready),
      .umi_in_cmd(umi_in_cmd), .umi_in_dstaddr(umi_in_dstaddr),
      .umi_in_srcaddr(umi_in_srcaddr), .umi_in_data(umi_in_data),
      .umi_out_valid(umi_out_valid), .umi_out_ready(umi_out_ready),
      .out_opcode(out_opcode), .out_size(out_size), .out_len(out_len), .out_atype(out_atype),
      .out_qos(out_qos), .out_prot(out_prot), .out_eom(out_eom), .out_eof(out_eof),
      .out_ex(out_ex), .out_user(out_user), .out_hostid(out_hostid),
      .out_user_extended(out_user_extended), .out_atomic(out_atomic), .out_error(out_error),
      .out_link(out_link), .out_link_resp(out_link_resp), .out_cmd(out_cmd),
      .out_dstaddr(out_dstaddr), .out_srcaddr(out_srcaddr), .out_data(out_data),
      .err_count(err_count)
   );

   // cls = {atomic, error, link, link_resp}
   function automatic dec_t mkdec(input logic [4:0] op, input logic [2:0] sz,
                                  input logic [7:0] len, input logic [7:0] atype,
                                  input logic [3:0] qos, input logic [1:0] prot,
                                  input logic eom, input logic eof, input logic ex,
                                  input logic [1:0] user, input logic [4:0] hid,
                                  input logic [18:0] uext, input logic [3:0] cls);
      return {op, sz, len, atype, qos, prot, eom, eof, ex, user, hid, uext, cls};
   endfunction

   function automatic exp_t mkexp(input logic [31:0] cmd, input dec_t d);
      exp_t e;
      e.dec  = d;
      e.cmd  = cmd;
      e.dst  = {cmd, ~cmd};
      e.src  = {~cmd, cmd ^ 32'h5A5A_A5A5};
      e.data = {8{cmd}};
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic drive(input exp_t e);
      umi_in_cmd     = e.cmd;
      umi_in_dstaddr = e.dst;
      umi_in_srcaddr = e.src;
      umi_in_data    = e.data;
      umi_in_valid   = 1'b1;
   endtask

   task automatic accept(input exp_t e);
      exp_q.push_back(e);
      if (e.dec.error && exp_err != 16'hFFFF) exp_err++;
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that took the packet.
   task automatic send(input logic [31:0] cmd, input dec_t d);
      exp_t e;
      bit   ok;
      e  = mkexp(cmd, d);
      ok = 1'b0;
      drive(e);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (umi_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: cmd %h never accepted, ready=%b", cmd, umi_in_ready);
      end else begin
         accept(e);
      end
      @(posedge clk);
      #1;
      umi_in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (umi_out_valid && umi_out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got cmd %h, expected no packet", out_cmd);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_act = {out_opcode, out_size, out_len, out_atype, out_qos, out_prot, out_eom,
                       out_eof, out_ex, out_user, out_hostid, out_user_extended, out_atomic,
                       out_error, out_link, out_link_resp};
            n_tests++;
            if (mon_act !== mon_e.dec) begin
               n_fail++;
               $display("FAIL decode cmd %h: got %h, expected %h", mon_e.cmd, mon_act,
                        mon_e.dec);
            end
            n_tests++;
            if ({out_cmd, out_dstaddr, out_srcaddr, out_data} !==
                {mon_e.cmd, mon_e.dst, mon_e.src, mon_e.data}) begin
               n_fail++;
               $display("FAIL raw: got cmd %h dst %h data %h, expected cmd %h dst %h data %h",
                        out_cmd, out_dstaddr, out_data, mon_e.cmd, mon_e.dst, mon_e.data);
            end
         end
      end
   end

   dec_t d_wr, d_at, d_lk, d_er, d_lr, d_full, d_sz2;

   initial begin
      d_wr   = mkdec(5'h03, 3'h0, 8'h23, 8'h00, 4'h1, 2'h0, 1, 0, 0, 2'h2, 5'h11, 19'h0, 4'b0000);
      d_at   = mkdec(5'h09, 3'h0, 8'h00, 8'hAB, 4'h0, 2'h0, 0, 0, 0, 2'h0, 5'h00, 19'h0, 4'b1000);
      d_lk   = mkdec(5'h0F, 3'h0, 8'h00, 8'h00, 4'h0, 2'h0, 0, 0, 0, 2'h0, 5'h00, 19'h7FFFF,
                     4'b0010);
      d_er   = mkdec(5'h0F, 3'h0, 8'h00, 8'h00, 4'h0, 2'h0, 0, 0, 0, 2'h0, 5'h00, 19'h0, 4'b0100);
      d_lr   = mkdec(5'h0E, 3'h0, 8'h00, 8'h00, 4'h0, 2'h0, 0, 0, 0, 2'h0, 5'h02, 19'h23456,
                     4'b0001);
      d_full = mkdec(5'h01, 3'h3, 8'h10, 8'h00, 4'h5, 2'h3, 1, 1, 1, 2'h0, 5'h1F, 19'h0, 4'b0000);
      d_sz2  = mkdec(5'h0F, 3'h2, 8'h55, 8'h00, 4'h0, 2'h0, 0, 0, 0, 2'h0, 5'h00, 19'h0, 4'b0000);

      reset          = 1'b1;
      umi_in_valid   = 1'b0;
      umi_out_ready  = 1'b0;
      umi_in_cmd     = '0;
      umi_in_dstaddr = '0;
      umi_in_srcaddr = '0;
      umi_in_data    = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'd0, umi_out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, umi_in_ready}, 32'd1);
      chk("rst_err_count", {16'd0, err_count}, 32'd0);
      reset         = 1'b0;
      umi_out_ready = 1'b1;
      @(posedge clk);
      #1;

      send(32'h8C41_2303, d_wr);
      @(negedge clk);
      chk("latency_valid", {31'd0, umi_out_valid}, 32'd1);
      @(posedge clk);
      #1;
      send(32'h0000_AB09, d_at);
      send(32'h07FF_FF2F, d_lk);
      chk("link_err_count", {16'd0, err_count}, 32'd0);
      send(32'h0000_000F, d_er);
      chk("err_count_one", {16'd0, err_count}, 32'd1);
      send(32'h1234_560E, d_lr);
      send(32'hF9F5_1061, d_full);
      send(32'h0000_554F, d_sz2);
      repeat (3) @(negedge clk);
      chk("drain_1", exp_q.size(), 32'd0);

      // Backpressure: two fill the FIFO, the third must wait.
      @(posedge clk);
      #1;
      umi_out_ready = 1'b0;
      send(32'h1234_560E, d_lr);
      send(32'hF9F5_1061, d_full);
      chk("full_in_ready", {31'd0, umi_in_ready}, 32'd0);
      chk("full_out_valid", {31'd0, umi_out_valid}, 32'd1);
      repeat (2) @(negedge clk);
      chk("stall_stable_cmd", out_cmd, 32'h1234_560E);
      chk("stall_stable_uext", {13'd0, out_user_extended}, 32'h23456);
      @(posedge clk);
      #1;
      fork
         send(32'h0000_554F, d_sz2);
         begin
            repeat (3) @(posedge clk);
            #1;
            umi_out_ready = 1'b1;
         end
      join
      repeat (5) @(negedge clk);
      chk("drain_bp", exp_q.size(), 32'd0);

      @(posedge clk);
      #1;
      for (int i = 0; i < 65537; i++) send(32'h0000_000F, d_er);
      chk("err_saturate", {16'd0, err_count}, 32'h0000_FFFF);
      chk("err_model", {16'd0, err_count}, {16'd0, exp_err});
      repeat (3) @(negedge clk);
      chk("drain_bulk", exp_q.size(), 32'd0);

      // Asynchronous reset with two entries held.
      @(posedge clk);
      #1;
      umi_out_ready = 1'b0;
      send(32'h8C41_2303, d_wr);
      send(32'h0000_AB09, d_at);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_out_valid", {31'd0, umi_out_valid}, 32'd0);
      chk("async_err_count", {16'd0, err_count}, 32'd0);
      chk("async_in_ready", {31'd0, umi_in_ready}, 32'd1);
      exp_q.delete();
      exp_err       = 16'd0;
      umi_out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_stale", {31'd0, umi_out_valid}, 32'd0);
      end
      reset = 1'b0;
      drive(mkexp(32'hF9F5_1061, d_full));
      chk("first_push_ready", {31'd0, umi_in_ready}, 32'd1);
      accept(mkexp(32'hF9F5_1061, d_full));
      @(posedge clk);
      #1;
      umi_in_valid = 1'b0;
      @(negedge clk);
      chk("first_push_valid", {31'd0, umi_out_valid}, 32'd1);
      repeat (3) @(negedge clk);
      chk("drain_final", exp_q.size(), 32'd0);
      chk("final_idle", {31'd0, umi_out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
